sr_alu_seq: RTL and testbench
=============================

Name: sr_alu_seq

Overview:
- Parametrised-width ALU for the schoolRISCV execute stage.
- Extends the single-cycle op set (ADD/SUB/OR/SRL/SLTU) with AND, XOR, SLL, SRA and SLT.
- Adds iterative unsigned multiply/divide ops: MUL, MULHU, DIVU, REMU.
- Valid/ready handshake on input and output, so the CPU control unit can stall on multi-cycle ops.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), localparam; shift-amount bits taken from srcB.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and oper presented.
- in_ready  out  1  block can accept an op this cycle.
- srcA  in  WIDTH  operand A.
- srcB  in  WIDTH  operand B.
- oper  in  4  operation code (shared header encodings).
- out_valid  out  1  result/zero valid; held until consumed.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- zero  out  1  registered, equals (result == 0).

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; result=0; zero=1; iteration counter and accumulators cleared.
- States:
  - IDLE: in_ready=1.
  - BUSY: iterative op running; in_ready=0.
  - DONE: out_valid=1; in_ready=0.
- Accept: op is taken when in_valid && in_ready. Operands and oper are latched; later input changes are ignored.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU):
  - Result is registered on the accept edge; state goes to DONE, so out_valid rises the next cycle (latency 1).
  - Arithmetic wraps modulo 2^WIDTH.
  - Shifts use srcB[SHW-1:0] only.
  - SLT is a signed compare; SLTU is unsigned. Both return 1 or 0, zero-extended.
  - Unknown oper code behaves as ADD.
- MUL / MULHU:
  - Shift-add, one multiplier bit per cycle; 2*WIDTH-bit product.
  - MUL returns product[WIDTH-1:0]; MULHU returns product[2*WIDTH-1:WIDTH].
- DIVU / REMU:
  - Restoring division, one quotient bit per cycle.
  - Divide by zero: DIVU returns all-ones; REMU returns srcA. Iteration still runs its full length unless the optional feature is enabled.
- Iterative latency: accept -> BUSY for exactly WIDTH cycles -> DONE. out_valid is first high WIDTH+1 cycles after the accept edge.
- DONE -> IDLE on out_valid && out_ready. result and zero keep their value after leaving DONE until the next op completes.
- No overlap: a new op cannot be accepted in the cycle the previous result is consumed (in_ready is 0 in DONE). Minimum issue interval is 2 cycles.
- out_ready low in DONE: stall indefinitely; result is stable.
- rst asserted in any state, including mid-BUSY: the op is aborted, no result is produced, and all outputs return to reset values on that edge.
- in_valid while in BUSY or DONE: ignored; no state change.

Optional Feature:
- Macro: SR_ALU_SEQ_EARLY_OUT_EN.
- Defined:
  - MUL/MULHU with either operand zero complete with latency 1 (result 0).
  - DIVU/REMU with srcB==0 complete with latency 1 (all-ones / srcA).
  - DIVU/REMU with srcA < srcB complete with latency 1 (0 / srcA).
- Undefined: every iterative op takes WIDTH+1 cycles regardless of operands. Results are identical in both builds.

Decomposition:
- Shared header sr_alu_seq.vh:
  - 4-bit oper encodings: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU.
  - State encodings IDLE/BUSY/DONE.
  - Helper macro ALU_IS_ITER(op).
- Sub-module sr_muldiv_iter:
  - Owns the shift-add and restoring-divide datapath and the iteration counter.
  - Interface: start, op select, done pulse, 2*WIDTH result.
- The top module keeps the FSM, the combinational single-cycle ops and the output registers.

Test Plan:
- ADD 0xFFFFFFFF + 1, out_ready=1 -> out_valid one cycle after accept, result=0, zero=1. SRA 0x80000000 by srcB=0x21 -> 0xC0000000 (shift 1).
- SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0. Hold out_ready=0 for 5 cycles -> result stable, in_ready=0, then DONE->IDLE on handshake.
- MUL 0x12345678 * 0x10 -> 0x23456780; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. out_valid exactly 33 cycles after accept (feature off).
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 0x55/0 -> 0x55. With SR_ALU_SEQ_EARLY_OUT_EN, divide-by-zero returns in 1 cycle.
- Assert rst at BUSY cycle 10 of a DIVU -> next cycle out_valid=0, result=0, zero=1, in_ready=1. A following ADD 2+3 returns 5.
- WIDTH=8 build: MUL 0x0F*0x11 -> 0xFF, MULHU 0x80*0x04 -> 0x02; latency 9 cycles.

Source files
------------

// File: rtl/sr_alu_seq_pkg.sv
// sr_alu_seq_pkg: shared operation codes, FSM state encoding and op-class helper for sr_alu_seq.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Codes 0..4 keep the original single-cycle schoolRISCV values. Codes 10 and 11 are unused
// and execute as ADD. The iterative ops sit in 12..15 so that oper[3:2]==2'b11 marks them
// and oper[1] separates divide from multiply.
package sr_alu_seq_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_SRL   = 4'd2;
  localparam logic [3:0] ALU_SLTU  = 4'd3;
  localparam logic [3:0] ALU_SUB   = 4'd4;
  localparam logic [3:0] ALU_AND   = 4'd5;
  localparam logic [3:0] ALU_XOR   = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRA   = 4'd8;
  localparam logic [3:0] ALU_SLT   = 4'd9;
  localparam logic [3:0] ALU_MUL   = 4'd12;
  localparam logic [3:0] ALU_MULHU = 4'd13;
  localparam logic [3:0] ALU_DIVU  = 4'd14;
  localparam logic [3:0] ALU_REMU  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for MUL, MULHU, DIVU and REMU, the ops handled by the iterative datapath.
  function automatic logic alu_is_iter(input logic [3:0] op);
    return (op[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/sr_muldiv_iter.sv
// sr_muldiv_iter: iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Latency: first iteration on the start edge, WIDTH iterations total; done pulses the cycle after the last.
// Backpressure: none; the caller only starts it when idle and must take res when done pulses.
//
// Ports: clk, rst (sync, active high); start, is_div, a, b sampled on the start edge;
// done is a one-cycle pulse; res = {hi, lo}: product for multiply, {remainder, quotient} for divide.
module sr_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] res
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic             div_q, run_q, done_q;
  logic [SHW-1:0]   cnt_q;

  // The start cycle iterates directly on the incoming operands, so the first bit is processed
  // without a separate load cycle.
  logic [WIDTH-1:0] cur_hi, cur_lo, cur_opnd;
  logic             cur_div;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;

  always_comb begin
    cur_hi   = start ? '0 : hi_q;
    cur_lo   = start ? (is_div ? a : b) : lo_q;
    cur_opnd = start ? (is_div ? b : a) : opnd_q;
    cur_div  = start ? is_div : div_q;

    // Multiply: hi accumulates the multiplicand when the multiplier LSB is set, then the whole
    // {carry, hi, lo} shifts right; multiplier bits drain out of lo as product bits fill it.
    mul_sum = {1'b0, cur_hi} + {1'b0, (cur_lo[0] ? cur_opnd : '0)};

    // Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
    // A zero divisor always subtracts, which gives an all-ones quotient and remainder == dividend.
    div_sh   = {cur_hi, cur_lo[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, cur_opnd});
    div_diff = div_sh[WIDTH-1:0] - cur_opnd;

    if (cur_div) begin
      nxt_hi = div_ge ? div_diff : div_sh[WIDTH-1:0];
      nxt_lo = {cur_lo[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], cur_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        hi_q   <= nxt_hi;
        lo_q   <= nxt_lo;
        opnd_q <= cur_opnd;
        div_q  <= is_div;
        cnt_q  <= SHW'(1);
        run_q  <= 1'b1;
      end else if (run_q) begin
        hi_q  <= nxt_hi;
        lo_q  <= nxt_lo;
        cnt_q <= cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign res  = {hi_q, lo_q};

endmodule

// File: rtl/sr_alu_seq.sv
// sr_alu_seq: schoolRISCV execute ALU with single-cycle ops plus iterative MUL/MULHU/DIVU/REMU.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for iterative ops (early-out may shorten).
// Backpressure: result held in DONE until out_ready; in_ready low in BUSY and DONE.
//
// Ports: clk, rst (sync, active high); in_valid/in_ready with srcA, srcB, oper;
// out_valid/out_ready with registered result and zero (result == 0).
// Build option: define SR_ALU_SEQ_EARLY_OUT_EN to finish trivial multiplies/divides in one cycle.
module sr_alu_seq
  import sr_alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [3:0]       oper,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  logic             accept;
  logic             is_iter;
  logic             md_start, md_done;
  logic [2*WIDTH-1:0] md_res;
  logic [WIDTH-1:0] alu_res, iter_res, res_d;
  logic             load_res;
  logic             early;
  logic [WIDTH-1:0] early_res;

  logic [SHW-1:0]          shamt;
  logic signed [WIDTH-1:0] src_a_s;

  assign accept   = in_valid && in_ready;
  assign is_iter  = alu_is_iter(oper);
  assign shamt    = srcB[SHW-1:0];
  assign src_a_s  = srcA;

  // Single-cycle ops on the live inputs; captured on the accept edge.
  always_comb begin
    alu_res = srcA + srcB;
    case (oper)
      ALU_SUB:  alu_res = srcA - srcB;
      ALU_AND:  alu_res = srcA & srcB;
      ALU_OR:   alu_res = srcA | srcB;
      ALU_XOR:  alu_res = srcA ^ srcB;
      ALU_SLL:  alu_res = srcA << shamt;
      ALU_SRL:  alu_res = srcA >> shamt;
      ALU_SRA:  alu_res = src_a_s >>> shamt;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
      default:  alu_res = srcA + srcB;
    endcase
  end

`ifdef SR_ALU_SEQ_EARLY_OUT_EN
  // Operand patterns whose answer is known without iterating.
  always_comb begin
    early     = 1'b0;
    early_res = '0;
    case (oper)
      ALU_MUL, ALU_MULHU: early = (srcA == '0) || (srcB == '0);
      ALU_DIVU: begin
        early     = (srcB == '0) || (srcA < srcB);
        early_res = (srcB == '0) ? '1 : '0;
      end
      ALU_REMU: begin
        early     = (srcB == '0) || (srcA < srcB);
        early_res = srcA;
      end
      default: early = 1'b0;
    endcase
  end
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  // High half is MULHU's product top and REMU's remainder.
  always_comb begin
    case (op_q)
      ALU_MULHU, ALU_REMU: iter_res = md_res[2*WIDTH-1:WIDTH];
      default:             iter_res = md_res[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    md_start = 1'b0;
    load_res = 1'b0;
    res_d    = alu_res;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_iter && !early) begin
            md_start = 1'b1;
            state_d  = BUSY;
          end else begin
            load_res = 1'b1;
            res_d    = is_iter ? early_res : alu_res;
            state_d  = DONE;
          end
        end
      end
      BUSY: begin
        if (md_done) begin
          load_res = 1'b1;
          res_d    = iter_res;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= ALU_ADD;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) op_q <= oper;
      if (load_res) begin
        result_q <= res_d;
        zero_q   <= (res_d == '0);
      end
    end
  end

  // oper[1] separates DIVU/REMU from MUL/MULHU in the iterative code range.
  sr_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_div (oper[1]),
    .a      (srcA),
    .b      (srcB),
    .done   (md_done),
    .res    (md_res)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_sr_alu_seq.sv
// tb_sr_alu_seq: directed checks of sr_alu_seq at WIDTH=32 and WIDTH=8.
// Latency: n/a.
// Backpressure: exercises out_ready stalls and ignored in_valid.
module tb_sr_alu_seq;
  import sr_alu_seq_pkg::*;

`ifdef SR_ALU_SEQ_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [31:0] srcA, srcB, result;
  logic [3:0]  oper;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8;
  logic [7:0]  srcA8, srcB8, result8;
  logic [3:0]  oper8;

  int total = 0;
  int bad   = 0;

  sr_alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .srcA(srcA), .srcB(srcB), .oper(oper), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero)
  );

  sr_alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .srcA(srcA8), .srcB(srcB8), .oper(oper8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .zero(zero8)
  );

  // Present one op, let it be taken on the next rising edge, then scramble the inputs.
  task automatic issue(input bit w8, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (w8) begin in_valid8 = 1'b1; oper8 = op; srcA8 = a[7:0]; srcB8 = b[7:0]; end
    else    begin in_valid  = 1'b1; oper  = op; srcA  = a;      srcB  = b;      end
    @(posedge clk);
    #1;
    in_valid  = 1'b0; oper  = ALU_SUB; srcA  = 32'hDEADBEEF; srcB  = 32'h0BADF00D;
    in_valid8 = 1'b0; oper8 = ALU_SUB; srcA8 = 8'hA5;        srcB8 = 8'h3C;
  endtask

  // Edges from the accept edge up to the one after which out_valid is seen; -1 on timeout.
  task automatic wait_done(input bit w8, output int lat);
    int n;
    for (n = 1; n <= 200; n++) begin
      if (w8 ? out_valid8 : out_valid) break;
      @(posedge clk);
      #1;
    end
    lat = (n > 200) ? -1 : n;
  endtask

  task automatic consume(input bit w8);
    @(negedge clk);
    if (w8) out_ready8 = 1'b1; else out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0; out_ready8 = 1'b0;
  endtask

  task automatic run_op(input bit w8, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
    issue(w8, op, a, b);
    wait_done(w8, lat);
    res = w8 ? {24'h0, result8} : result;
    consume(w8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    total++; if (result !== 32'h0)    begin bad++; $display("FAIL reset_result got %h want 0", result); end
    total++; if (zero !== 1'b1)       begin bad++; $display("FAIL reset_zero got %b want 1", zero); end
    total++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0)
      begin bad++; $display("FAIL reset_w8 got rdy=%b vld=%b want 1 0", in_ready8, out_valid8); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_cycle();
    int lat; logic [31:0] r;
    run_op(0, ALU_ADD, 32'hFFFFFFFF, 32'h1, lat, r);
    total++; if (lat !== 1)        begin bad++; $display("FAIL add_wrap_latency got %0d want 1", lat); end
    total++; if (r !== 32'h0)      begin bad++; $display("FAIL add_wrap got %h want 0", r); end
    total++; if (zero !== 1'b1)    begin bad++; $display("FAIL add_wrap_zero got %b want 1", zero); end
    run_op(0, ALU_SRA, 32'h80000000, 32'h21, lat, r);
    total++; if (r !== 32'hC0000000) begin bad++; $display("FAIL sra got %h want c0000000", r); end
    total++; if (zero !== 1'b0)    begin bad++; $display("FAIL sra_zero got %b want 0", zero); end
    run_op(0, ALU_SUB, 32'd5, 32'd7, lat, r);
    total++; if (r !== 32'hFFFFFFFE) begin bad++; $display("FAIL sub got %h want fffffffe", r); end
    run_op(0, ALU_AND, 32'h0000F0F0, 32'h0000FF00, lat, r);
    total++; if (r !== 32'h0000F000) begin bad++; $display("FAIL and got %h want 0000f000", r); end
    run_op(0, ALU_OR, 32'h0000F0F0, 32'h0000FF00, lat, r);
    total++; if (r !== 32'h0000FFF0) begin bad++; $display("FAIL or got %h want 0000fff0", r); end
    run_op(0, ALU_XOR, 32'hFF00FF00, 32'h0FF00FF0, lat, r);
    total++; if (r !== 32'hF0F0F0F0) begin bad++; $display("FAIL xor got %h want f0f0f0f0", r); end
    run_op(0, ALU_SLL, 32'h1, 32'h3F, lat, r);
    total++; if (r !== 32'h80000000) begin bad++; $display("FAIL sll got %h want 80000000", r); end
    run_op(0, ALU_SRL, 32'h80000000, 32'h24, lat, r);
    total++; if (r !== 32'h08000000) begin bad++; $display("FAIL srl got %h want 08000000", r); end
    run_op(0, 4'd10, 32'd3, 32'd4, lat, r);
    total++; if (r !== 32'd7)      begin bad++; $display("FAIL unknown_op got %h want 7", r); end
  endtask

  task automatic test_slt();
    int lat; logic [31:0] r;
    run_op(0, ALU_SLT, 32'hFFFFFFFF, 32'h1, lat, r);
    total++; if (r !== 32'h1) begin bad++; $display("FAIL slt got %h want 1", r); end
    run_op(0, ALU_SLTU, 32'hFFFFFFFF, 32'h1, lat, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL sltu got %h want 0", r); end
  endtask

  task automatic test_stall();
    int lat;
    issue(0, ALU_XOR, 32'h12345678, 32'h0000FFFF);
    wait_done(0, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL stall_latency got %0d want 1", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; oper = ALU_ADD; srcA = 32'd1; srcB = 32'd1;
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h1234A987)
        begin bad++; $display("FAIL stall_hold got vld=%b rdy=%b res=%h want 1 0 1234a987", out_valid, in_ready, result); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume(0);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL stall_release got vld=%b rdy=%b want 0 1", out_valid, in_ready); end
    total++; if (result !== 32'h1234A987) begin bad++; $display("FAIL stall_keep got %h want 1234a987", result); end
  endtask

  task automatic test_mul();
    int lat; logic [31:0] r;
    run_op(0, ALU_MUL, 32'h12345678, 32'h10, lat, r);
    total++; if (r !== 32'h23456780) begin bad++; $display("FAIL mul got %h want 23456780", r); end
    total++; if (lat !== 33)         begin bad++; $display("FAIL mul_latency got %0d want 33", lat); end
    run_op(0, ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, r);
    total++; if (r !== 32'hFFFFFFFE) begin bad++; $display("FAIL mulhu got %h want fffffffe", r); end
    total++; if (lat !== 33)         begin bad++; $display("FAIL mulhu_latency got %0d want 33", lat); end
    run_op(0, ALU_MUL, 32'h0, 32'h1234, lat, r);
    total++; if (r !== 32'h0 || zero !== 1'b1) begin bad++; $display("FAIL mul_zero got %h z=%b want 0 1", r, zero); end
    total++; if (lat !== EARLY_LAT)  begin bad++; $display("FAIL mul_zero_latency got %0d want %0d", lat, EARLY_LAT); end
  endtask

  task automatic test_div();
    int lat; logic [31:0] r;
    run_op(0, ALU_DIVU, 32'd100, 32'd7, lat, r);
    total++; if (r !== 32'd14) begin bad++; $display("FAIL divu got %h want 0000000e", r); end
    total++; if (lat !== 33)   begin bad++; $display("FAIL divu_latency got %0d want 33", lat); end
    run_op(0, ALU_REMU, 32'd100, 32'd7, lat, r);
    total++; if (r !== 32'd2)  begin bad++; $display("FAIL remu got %h want 2", r); end
    run_op(0, ALU_DIVU, 32'h1234, 32'h0, lat, r);
    total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu_by0 got %h want ffffffff", r); end
    total++; if (lat !== EARLY_LAT)  begin bad++; $display("FAIL divu_by0_latency got %0d want %0d", lat, EARLY_LAT); end
    run_op(0, ALU_REMU, 32'h55, 32'h0, lat, r);
    total++; if (r !== 32'h55) begin bad++; $display("FAIL remu_by0 got %h want 55", r); end
    run_op(0, ALU_DIVU, 32'd5, 32'd9, lat, r);
    total++; if (r !== 32'h0)  begin bad++; $display("FAIL divu_small got %h want 0", r); end
    total++; if (lat !== EARLY_LAT) begin bad++; $display("FAIL divu_small_latency got %0d want %0d", lat, EARLY_LAT); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] r;
    run_op(0, ALU_MUL, 32'd3, 32'd5, lat, r);
    total++; if (r !== 32'd15) begin bad++; $display("FAIL b2b_mul1 got %h want f", r); end
    // in_valid held through BUSY must not disturb the running op
    issue(0, ALU_MUL, 32'd7, 32'd6);
    @(negedge clk);
    in_valid = 1'b1; oper = ALU_ADD; srcA = 32'd1; srcB = 32'd1;
    wait_done(0, lat);
    in_valid = 1'b0;
    r = result;
    consume(0);
    total++; if (r !== 32'd42) begin bad++; $display("FAIL b2b_mul2 got %h want 2a", r); end
    total++; if (lat !== 33)   begin bad++; $display("FAIL b2b_latency got %0d want 33", lat); end
  endtask

  task automatic test_rst_busy();
    int lat; int seen; logic [31:0] r;
    issue(0, ALU_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL rst_busy_hs got vld=%b rdy=%b want 0 1", out_valid, in_ready); end
    total++; if (result !== 32'h0 || zero !== 1'b1)
      begin bad++; $display("FAIL rst_busy_regs got %h z=%b want 0 1", result, zero); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_busy_ghost got %0d want 0", seen); end
    run_op(0, ALU_ADD, 32'd2, 32'd3, lat, r);
    total++; if (r !== 32'd5 || lat !== 1) begin bad++; $display("FAIL rst_busy_add got %h lat=%0d want 5 1", r, lat); end
  endtask

  task automatic test_width8();
    int lat; logic [31:0] r;
    run_op(1, ALU_MUL, 32'h0F, 32'h11, lat, r);
    total++; if (r !== 32'hFF) begin bad++; $display("FAIL w8_mul got %h want ff", r); end
    total++; if (lat !== 9)    begin bad++; $display("FAIL w8_mul_latency got %0d want 9", lat); end
    run_op(1, ALU_MULHU, 32'h80, 32'h04, lat, r);
    total++; if (r !== 32'h02) begin bad++; $display("FAIL w8_mulhu got %h want 02", r); end
    total++; if (lat !== 9)    begin bad++; $display("FAIL w8_mulhu_latency got %0d want 9", lat); end
    run_op(1, ALU_DIVU, 32'd200, 32'd7, lat, r);
    total++; if (r !== 32'd28) begin bad++; $display("FAIL w8_divu got %h want 1c", r); end
    run_op(1, ALU_REMU, 32'd200, 32'd7, lat, r);
    total++; if (r !== 32'd4)  begin bad++; $display("FAIL w8_remu got %h want 4", r); end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; srcA = '0; srcB = '0; oper = ALU_ADD;
    in_valid8 = 1'b0; out_ready8 = 1'b0; srcA8 = '0; srcB8 = '0; oper8 = ALU_ADD;
    test_reset();
    test_single_cycle();
    test_slt();
    test_stall();
    test_mul();
    test_div();
    test_back_to_back();
    test_rst_busy();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
